// File: rtl/ft_bus_pkg.sv
// Shared definitions for the FTDI-style bus responder: FSM states, status and command bit
// positions, and the status byte packer.
package ft_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_DRIVE = 2'd1,
    RD_DONE  = 2'd2
  } state_e;

  localparam int unsigned ST_RXAVAIL = 0;
  localparam int unsigned ST_TXSPACE = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_UDF     = 3;
  localparam int unsigned ST_PERR    = 4;

  localparam int unsigned CMD_CLR   = 0;
  localparam int unsigned CMD_FLUSH = 1;

  localparam logic [7:0] STATUS_RESET = 8'h02;

  // rxavail/txspace are named from the host's point of view.
  function automatic logic [7:0] pack_status(input logic rxavail, input logic txspace,
                                             input logic ovf, input logic udf,
                                             input logic perr);
    logic [7:0] s;
    s             = '0;
    s[ST_RXAVAIL] = rxavail;
    s[ST_TXSPACE] = txspace;
    s[ST_OVF]     = ovf;
    s[ST_UDF]     = udf;
    s[ST_PERR]    = perr;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and a synchronous flush that overrides
// any same-cycle push or pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ft_bus_responder.sv
// Device-side responder for the 8-bit FTDI-style host bus: host reads drain the to-host FIFO
// or the status byte, host writes fill the from-host FIFO or the command register.
module ft_bus_responder
  import ft_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_d_in,
  output logic [7:0] bus_d_out,
  output logic       bus_d_oe,
  input  logic       bus_cs,
  input  logic       bus_a0,
  input  logic       bus_rd,
  input  logic       bus_wr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] status
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = FIFO_DEPTH[CW-1:0];

  logic [SYNC_STAGES-1:0] cs_sync_q, a0_sync_q, rd_sync_q, wr_sync_q;
  logic [7:0]             d_sync_q [SYNC_STAGES];
  logic                   rd_dly_q, wr_dly_q;
  logic                   rd_arm_q, wr_arm_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   cs_s, a0_s, rd_s, wr_s;
  logic [7:0]             d_s;

  state_e     state_q;
  logic       pop_pend_q;
  logic       ovf_q, udf_q, perr_q;
  logic [7:0] status_q;

  logic          rd_fall, rd_rise, wr_rise;
  logic          in_idle, rd_go, wr_sel, host_wr;
  logic          perr_set, ovf_set, udf_set;
  logic          cmd_wr, flush, clr;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]    tx_head, rx_head, status_byte;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [CW-1:0] tx_count, rx_count;

  // Strobes reset high so a bus left idle produces no spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      a0_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
      rd_dly_q  <= 1'b1;
      wr_dly_q  <= 1'b1;
      rd_arm_q  <= 1'b0;
      wr_arm_q  <= 1'b0;
      fill_q    <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus_cs};
      a0_sync_q   <= {a0_sync_q[SYNC_STAGES-2:0], bus_a0};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], bus_rd};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], bus_wr};
      d_sync_q[0] <= bus_d_in;
      for (int i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
      rd_dly_q    <= rd_s;
      wr_dly_q    <= wr_s;
      fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      // A strobe counts only once it has been seen high on real (post-reset) samples.
      rd_arm_q    <= rd_arm_q | (fill_q[SYNC_STAGES] & rd_s);
      wr_arm_q    <= wr_arm_q | (fill_q[SYNC_STAGES] & wr_s);
    end
  end

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign a0_s = a0_sync_q[SYNC_STAGES-1];
  assign rd_s = rd_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign d_s  = d_sync_q[SYNC_STAGES-1];

  assign rd_fall = rd_arm_q & rd_dly_q & ~rd_s;
  assign rd_rise = rd_arm_q & ~rd_dly_q & rd_s;
  assign wr_rise = wr_arm_q & ~wr_dly_q & wr_s;

  assign in_idle  = (state_q == IDLE);
  assign rd_go    = in_idle & rd_fall & ~cs_s;
  assign wr_sel   = wr_rise & ~cs_s;
  assign host_wr  = in_idle & wr_sel & ~rd_go;
  assign perr_set = wr_sel & ~host_wr;

  assign rx_push = host_wr & ~a0_s & ~rx_full;
  assign ovf_set = host_wr & ~a0_s & rx_full;
  assign cmd_wr  = host_wr & a0_s;
  assign flush   = cmd_wr & d_s[CMD_FLUSH];
  assign clr     = cmd_wr & d_s[CMD_CLR];
  assign udf_set = rd_go & ~a0_s & tx_empty;

  assign tx_push = tx_valid & ~tx_full;
  assign tx_pop  = (state_q == RD_DONE) & pop_pend_q;
  assign rx_pop  = rx_ready & ~rx_empty;

  assign status_byte = pack_status(~tx_empty, ~rx_full, ovf_q, udf_q, perr_q);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (tx_data),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (d_s),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  assign tx_ready = ~tx_full;
  assign rx_valid = ~rx_empty;
  assign rx_data  = rx_head;
  assign status   = status_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bus_d_out  <= '0;
      bus_d_oe   <= 1'b0;
      pop_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      perr_q     <= 1'b0;
      status_q   <= STATUS_RESET;
    end else begin
      ovf_q    <= (ovf_q & ~clr) | ovf_set;
      udf_q    <= (udf_q & ~clr) | udf_set;
      perr_q   <= (perr_q & ~clr) | perr_set;
      status_q <= status_byte;
      unique case (state_q)
        IDLE: begin
          if (rd_go) begin
            state_q    <= RD_DRIVE;
            bus_d_oe   <= 1'b1;
            // The pop is deferred to RD_DONE so the host sees a stable byte all strobe long.
            pop_pend_q <= ~a0_s & ~tx_empty;
            if (a0_s)           bus_d_out <= status_byte;
            else if (!tx_empty) bus_d_out <= tx_head;
            else                bus_d_out <= 8'h00;
          end
        end
        RD_DRIVE: begin
          if (rd_rise || cs_s) begin
            state_q  <= RD_DONE;
            bus_d_oe <= 1'b0;
          end
        end
        RD_DONE: begin
          state_q    <= IDLE;
          pop_pend_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          bus_d_oe <= 1'b0;
        end
      endcase
    end
  end

  a_tx_count: assert property (@(posedge clk) disable iff (rst)
    (tx_empty == (tx_count == '0)) && (tx_full == (tx_count == CNT_FULL)));
  a_rx_count: assert property (@(posedge clk) disable iff (rst)
    (rx_empty == (rx_count == '0)) && (rx_full == (rx_count == CNT_FULL)));

endmodule

// File: tb/tb_ft_bus_responder.sv
// Bench for ft_bus_responder: a directed vector table, hand-built bus corner cases, a host
// loopback, and randomized traffic against a queue-based model.
module tb_ft_bus_responder;

  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  typedef enum int {OpPush, OpRead, OpWrite, OpPopRx, OpStat, OpRxValid} op_e;
  typedef struct {
    op_e        op;
    logic       a0;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_d_in, bus_d_out;
  logic       bus_d_oe, bus_cs, bus_a0, bus_rd, bus_wr;
  logic [7:0] tx_data, rx_data, status;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t       vecs[$];
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_ovf, m_udf, m_perr;

  always #5 clk = ~clk;

  ft_bus_responder #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_d_in  (bus_d_in),
    .bus_d_out (bus_d_out),
    .bus_d_oe  (bus_d_oe),
    .bus_cs    (bus_cs),
    .bus_a0    (bus_a0),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .status    (status)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input op_e op, input logic a0, input logic [7:0] data,
                     input logic [7:0] exp);
    vec_t v;
    v.op   = op;
    v.a0   = a0;
    v.data = data;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    s    = '0;
    s[0] = (m_tx.size() != 0);
    s[1] = (m_rx.size() < DEPTH);
    s[2] = m_ovf;
    s[3] = m_udf;
    s[4] = m_perr;
    return s;
  endfunction

  task automatic bus_read(input logic a0v, output logic [7:0] data,
                          output int lat_on, output int lat_off);
    bus_cs = 1'b0;
    bus_a0 = a0v;
    tick(2);
    bus_rd = 1'b0;
    lat_on = 0;
    do begin tick(); lat_on++; end while (!bus_d_oe && lat_on < 20);
    chk("rd_oe_on", bus_d_oe, 1);
    data = bus_d_out;
    tick(2);
    bus_rd  = 1'b1;
    lat_off = 0;
    do begin tick(); lat_off++; end while (bus_d_oe && lat_off < 20);
    chk("rd_oe_off", bus_d_oe, 0);
    bus_cs = 1'b1;
    tick(3);
  endtask

  task automatic bus_write(input logic a0v, input logic [7:0] v);
    bus_cs   = 1'b0;
    bus_a0   = a0v;
    bus_d_in = v;
    tick();
    bus_wr = 1'b0;
    tick(3);
    bus_wr = 1'b1;
    tick(3);
    bus_cs = 1'b1;
    tick(2);
  endtask

  task automatic local_push(input logic [7:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
  endtask

  task automatic local_pop();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         lon, loff;

    rst = 1'b1; bus_cs = 1'b1; bus_rd = 1'b1; bus_wr = 1'b1; bus_a0 = 1'b0;
    bus_d_in = '0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    tick(4);
    chk("rst_oe", bus_d_oe, 0);
    chk("rst_dout", bus_d_out, 8'h00);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_status", status, 8'h02);
    rst = 1'b0;
    tick(6);

    // Status read with strobe-to-enable latency on both edges.
    bus_read(1'b1, b, lon, loff);
    chk("lat_status", b, 8'h02);
    chk("lat_oe_on", lon, LAT);
    chk("lat_oe_off", loff, LAT);

    add(OpStat,    1'b0, 8'h00, 8'h02);
    add(OpRead,    1'b1, 8'h00, 8'h02);
    add(OpPush,    1'b0, 8'hA5, 8'h00);
    add(OpPush,    1'b0, 8'h3C, 8'h00);
    add(OpStat,    1'b0, 8'h00, 8'h03);
    add(OpRead,    1'b0, 8'h00, 8'hA5);
    add(OpStat,    1'b0, 8'h00, 8'h03);
    add(OpRead,    1'b0, 8'h00, 8'h3C);
    add(OpStat,    1'b0, 8'h00, 8'h02);
    add(OpWrite,   1'b0, 8'h11, 8'h00);
    add(OpWrite,   1'b0, 8'h22, 8'h00);
    add(OpWrite,   1'b0, 8'h33, 8'h00);
    add(OpStat,    1'b0, 8'h00, 8'h02);
    add(OpPopRx,   1'b0, 8'h00, 8'h11);
    add(OpPopRx,   1'b0, 8'h00, 8'h22);
    add(OpPopRx,   1'b0, 8'h00, 8'h33);
    add(OpRxValid, 1'b0, 8'h00, 8'h00);
    add(OpRead,    1'b0, 8'h00, 8'h00);
    add(OpStat,    1'b0, 8'h00, 8'h0A);
    add(OpWrite,   1'b1, 8'h01, 8'h00);
    add(OpStat,    1'b0, 8'h00, 8'h02);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OpPush:  local_push(vecs[i].data);
        OpWrite: bus_write(vecs[i].a0, vecs[i].data);
        OpRead: begin
          bus_read(vecs[i].a0, b, lon, loff);
          chk($sformatf("vec%0d_read", i), b, vecs[i].exp);
        end
        OpPopRx: begin
          chk($sformatf("vec%0d_rx_valid", i), rx_valid, 1);
          chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp);
          local_pop();
        end
        OpStat:    chk($sformatf("vec%0d_status", i), status, vecs[i].exp);
        OpRxValid: chk($sformatf("vec%0d_rx_valid", i), rx_valid, vecs[i].exp[0]);
        default:   ;
      endcase
    end

    // Write strobe pulsed while a read is being driven.
    local_push(8'h5A);
    bus_cs = 1'b0; bus_a0 = 1'b0; tick(2);
    bus_rd = 1'b0;
    lon = 0;
    do begin tick(); lon++; end while (!bus_d_oe && lon < 20);
    chk("wr_in_rd_data", bus_d_out, 8'h5A);
    bus_d_in = 8'h77;
    bus_wr = 1'b0; tick(3);
    bus_wr = 1'b1; tick(4);
    bus_rd = 1'b1;
    loff = 0;
    do begin tick(); loff++; end while (bus_d_oe && loff < 20);
    chk("wr_in_rd_oe_off", bus_d_oe, 0);
    bus_cs = 1'b1; tick(3);
    chk("wr_in_rd_status", status, 8'h12);
    chk("wr_in_rd_rx_valid", rx_valid, 0);
    bus_write(1'b1, 8'h01);
    chk("clr_status", status, 8'h02);

    // Read fall and write rise reach the edge detectors in the same cycle.
    bus_cs = 1'b0; bus_a0 = 1'b0; bus_d_in = 8'h99; tick(2);
    bus_wr = 1'b0; tick(4);
    bus_rd = 1'b0; bus_wr = 1'b1;
    lon = 0;
    do begin tick(); lon++; end while (!bus_d_oe && lon < 20);
    chk("simul_oe", bus_d_oe, 1);
    chk("simul_data", bus_d_out, 8'h00);
    tick(2);
    bus_rd = 1'b1;
    loff = 0;
    do begin tick(); loff++; end while (bus_d_oe && loff < 20);
    bus_cs = 1'b1; tick(3);
    chk("simul_status", status, 8'h1A);
    chk("simul_rx_valid", rx_valid, 0);
    bus_write(1'b1, 8'h01);

    // Overflow on the seventeenth host byte.
    for (int i = 0; i <= DEPTH; i++) bus_write(1'b0, 8'(8'h40 + i));
    chk("ovf_status", status, 8'h04);
    bus_write(1'b1, 8'h01);
    chk("ovf_clr_status", status, 8'h00);
    rx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_rx_valid", rx_valid, 1);
      chk("ovf_rx_data", rx_data, 8'(8'h40 + i));
      tick();
    end
    rx_ready = 1'b0;
    tick();
    chk("ovf_drained", rx_valid, 0);
    chk("ovf_end_status", status, 8'h02);

    // Strobes already low when reset releases must be ignored.
    bus_cs = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_a0 = 1'b0; bus_d_in = 8'h66;
    rst = 1'b1; tick(4);
    rst = 1'b0; tick(8);
    chk("held_rd_oe", bus_d_oe, 0);
    bus_wr = 1'b1; tick(5);
    chk("held_wr_rx_valid", rx_valid, 0);
    chk("held_wr_status", status, 8'h02);
    bus_rd = 1'b1; tick(4);
    bus_cs = 1'b1; tick(3);
    bus_read(1'b1, b, lon, loff);
    chk("held_then_read", b, 8'h02);

    // Host loopback of 0x00..0xFF through both FIFOs.
    for (int base = 0; base < 256; base += DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tx_ready !== 1'b1) chk("lb_tx_ready", tx_ready, 1);
        local_push(8'(base + i));
      end
      for (int i = 0; i < DEPTH; i++) begin
        bus_read(1'b0, b, lon, loff);
        bus_write(1'b0, b);
      end
      for (int i = 0; i < DEPTH; i++) begin
        chk("lb_rx_data", {7'b0, rx_valid, rx_data}, {7'b0, 1'b1, 8'(base + i)});
        local_pop();
      end
    end
    chk("lb_status", status, 8'h02);

    // Randomized traffic against the queue model.
    m_tx = {}; m_rx = {}; m_ovf = 1'b0; m_udf = 1'b0; m_perr = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      logic [7:0]  v;
      r = $urandom_range(0, 9);
      v = 8'($urandom);
      if (r <= 1) begin
        chk("rnd_tx_ready", tx_ready, (m_tx.size() < DEPTH));
        local_push(v);
        if (m_tx.size() < DEPTH) m_tx.push_back(v);
      end else if (r <= 3) begin
        chk("rnd_rx_valid", rx_valid, (m_rx.size() != 0));
        if (m_rx.size() != 0) begin
          chk("rnd_rx_data", rx_data, m_rx[0]);
          void'(m_rx.pop_front());
        end
        local_pop();
      end else if (r <= 5) begin
        logic [7:0] e;
        if (m_tx.size() != 0) e = m_tx.pop_front();
        else begin e = 8'h00; m_udf = 1'b1; end
        bus_read(1'b0, b, lon, loff);
        chk("rnd_read_data", b, e);
      end else if (r == 6) begin
        logic [7:0] e;
        e = m_status();
        bus_read(1'b1, b, lon, loff);
        chk("rnd_read_status", b, e);
      end else if (r <= 8) begin
        bus_write(1'b0, v);
        if (m_rx.size() < DEPTH) m_rx.push_back(v);
        else m_ovf = 1'b1;
      end else begin
        v = 8'($urandom_range(0, 3));
        bus_write(1'b1, v);
        if (v[0]) begin m_ovf = 1'b0; m_udf = 1'b0; m_perr = 1'b0; end
        if (v[1]) begin m_tx = {}; m_rx = {}; end
      end
      chk("rnd_status", status, m_status());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
